// File: rtl/inst_ram_resp.sv
// Instruction RAM with a fixed-latency fetch port and a side-band preload port.
// One request in flight; the response is a single-cycle rvalid pulse with a fault flag.
module inst_ram_resp #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WAIT  = 1,
  parameter logic [31:0] BASE  = 32'h1c00_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_en,
  input  logic [31:0]                inst_addr,
  output logic                       inst_ready,
  output logic                       inst_rvalid,
  output logic [31:0]                inst_rdata,
  output logic                       inst_err,
  input  logic                       load_we,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [31:0]                load_data
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = 4;
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic            ready_q, ready_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            accept_c;
  logic [31:0]     rd_addr_c;
  logic [31:0]     offset_c;
  logic            fault_c;
  logic [AW-1:0]   idx_c;

  logic [31:0]     mem [DEPTH];

  // Preload port; no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_data;
    end
  end

  // Next state, response payload captured on the edge that enters RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rvalid_d  = 1'b0;
    rdata_d   = 32'h0;
    err_d     = 1'b0;
    rd_addr_c = addr_q;
    accept_c  = inst_en && ready_q;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept_c) begin
          addr_d    = inst_addr;
          cnt_d     = CW'(WAIT - 32'd1);
          state_d   = (WAIT == 0) ? ST_RESP : ST_WAIT;
          rd_addr_c = inst_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Wrapped subtraction pushes addresses below BASE out of range as well.
    offset_c = rd_addr_c - BASE;
    fault_c  = (rd_addr_c[1:0] != 2'b00) || (rd_addr_c < BASE) || (offset_c >= SPAN);
    idx_c    = offset_c[AW+1:2];

    ready_d = (state_d != ST_WAIT);
    if (state_d == ST_RESP) begin
      rvalid_d = 1'b1;
      err_d    = fault_c;
      rdata_d  = fault_c ? 32'h0 : mem[idx_c];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign inst_ready  = ready_q;
  assign inst_rvalid = rvalid_q;
  assign inst_rdata  = rdata_q;
  assign inst_err    = err_q;

endmodule

// File: tb/tb_inst_ram_resp.sv
// Bench for inst_ram_resp: three instances (WAIT=0,1,3) share one stimulus stream and
// are checked every cycle against a cycle-count/array reference model.
module tb_inst_ram_resp;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1c00_0000;
  localparam int          NI    = 3;

  function automatic int unsigned wait_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  la;
  logic [31:0] ld;
  logic        rdy [NI];
  logic        rv  [NI];
  logic [31:0] rd  [NI];
  logic        er  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    inst_ram_resp #(.DEPTH(DEPTH), .WAIT(wait_of(g)), .BASE(BASE)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .inst_en    (en),
      .inst_addr  (addr),
      .inst_ready (rdy[g]),
      .inst_rvalid(rv[g]),
      .inst_rdata (rd[g]),
      .inst_err   (er[g]),
      .load_we    (we),
      .load_addr  (la),
      .load_data  (ld)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  bit          rdy_m    [NI];
  int          last_c   [NI];
  bit          pend_v   [NI];
  int          pend_due [NI];
  logic [31:0] pend_a   [NI];

  // Observed responses
  int          resp_cnt   [NI];
  int          resp_cyc   [NI];
  logic [31:0] last_rd    [NI];
  logic        last_er    [NI];
  int          before_cnt [NI];
  int          acc_cyc;

  task automatic check(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", nm, k, cyc, got, exp);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] a);
    logic [63:0] a64, lo, hi;
    a64 = {32'd0, a};
    lo  = {32'd0, BASE};
    hi  = lo + 64'(DEPTH) * 64'd4;
    return (a % 4 != 0) || (a64 < lo) || (a64 >= hi);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off / 4);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      rdy_m[k]  = 1'b0;
      last_c[k] = -100;
      pend_v[k] = 1'b0;
    end
  endtask

  // One clock: model the edge, then compare every instance just after it.
  task automatic tick();
    logic [31:0] exp_d;
    logic        exp_e, exp_v, exp_r;
    int          w;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      w = int'(wait_of(k));
      if (rst && en && rdy_m[k]) begin
        pend_v[k]   = 1'b1;
        pend_due[k] = cyc + w;
        pend_a[k]   = addr;
        last_c[k]   = cyc;
      end
      exp_v = 1'b0;
      exp_e = 1'b0;
      exp_d = 32'h0;
      if (rst && pend_v[k] && pend_due[k] == cyc) begin
        exp_v     = 1'b1;
        exp_e     = is_fault(pend_a[k]);
        exp_d     = exp_e ? 32'h0 : ref_mem[word_of(pend_a[k])];
        pend_v[k] = 1'b0;
      end
      exp_r    = rst && !(cyc >= last_c[k] && cyc < last_c[k] + w);
      rdy_m[k] = exp_r;
      check("cycle", k, 64'({rdy[k], rv[k], er[k], rd[k]}), 64'({exp_r, exp_v, exp_e, exp_d}));
      if (rv[k] === 1'b1) begin
        resp_cnt[k]++;
        resp_cyc[k] = cyc;
        last_rd[k]  = rd[k];
        last_er[k]  = er[k];
      end
    end
    if (we) ref_mem[la] = ld;
  endtask

  task automatic wait_resp();
    bit done;
    for (int n = 0; n < 16; n++) begin
      done = 1'b1;
      for (int k = 0; k < NI; k++) if (resp_cnt[k] <= before_cnt[k]) done = 1'b0;
      if (done) break;
      tick();
    end
    for (int k = 0; k < NI; k++) check("resp_seen", k, 64'(resp_cnt[k] > before_cnt[k]), 64'd1);
  endtask

  task automatic issue(input logic [31:0] a);
    for (int k = 0; k < NI; k++) before_cnt[k] = resp_cnt[k];
    en   = 1'b1;
    addr = a;
    tick();
    acc_cyc = cyc;
    en = 1'b0;
    wait_resp();
  endtask

  typedef struct {
    logic [31:0] a;
    logic        e;
    logic [31:0] d;
  } vec_t;

  vec_t vt [8];
  int   base2;

  initial begin
    rst = 1'b0; en = 1'b0; addr = '0; we = 1'b0; la = '0; ld = '0;
    for (int k = 0; k < NI; k++) resp_cnt[k] = 0;
    model_reset();

    // Reset state
    #2;
    for (int k = 0; k < NI; k++) check("reset_outs", k, 64'({rdy[k], rv[k], er[k], rd[k]}), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Preload: mem[0] is the canonical first instruction, the rest a tagged pattern
    for (int i = 0; i < int'(DEPTH); i++) begin
      we = 1'b1;
      la = 4'(i);
      ld = (i == 0) ? 32'h0280_0401 : (32'hC0DE_0000 | 32'(i));
      tick();
    end
    we = 1'b0;
    tick();

    vt[0] = '{32'h1c00_0000, 1'b0, 32'h0280_0401};
    vt[1] = '{32'h1c00_0004, 1'b0, 32'hC0DE_0001};
    vt[2] = '{32'h1c00_0002, 1'b1, 32'h0};
    vt[3] = '{32'h1bff_fffc, 1'b1, 32'h0};
    vt[4] = '{32'h1c00_0040, 1'b1, 32'h0};
    vt[5] = '{32'h1c00_003c, 1'b0, 32'hC0DE_000F};
    vt[6] = '{32'h0000_0000, 1'b1, 32'h0};
    vt[7] = '{32'hffff_fffc, 1'b1, 32'h0};

    // Response is sampled just after edge accept+WAIT, captured by the requester at accept+WAIT+1.
    for (int v = 0; v < 8; v++) begin
      issue(vt[v].a);
      for (int k = 0; k < NI; k++) begin
        check("table_resp", k, 64'({last_er[k], last_rd[k]}), 64'({vt[v].e, vt[v].d}));
        check("latency", k, 64'(resp_cyc[k] - acc_cyc), 64'(wait_of(k)));
      end
    end
    tick();

    // Back-to-back fetches with WAIT=0
    en = 1'b1; addr = 32'h1c00_0000; tick();
    check("b2b_0", 0, 64'({rv[0], rd[0]}), 64'({1'b1, 32'h0280_0401}));
    addr = 32'h1c00_0004; tick();
    check("b2b_1", 0, 64'({rv[0], rd[0]}), 64'({1'b1, 32'hC0DE_0001}));
    addr = 32'h1c00_0008; tick();
    check("b2b_2", 0, 64'({rv[0], rd[0]}), 64'({1'b1, 32'hC0DE_0002}));
    en = 1'b0;
    repeat (6) tick();

    // inst_en pulsed while the WAIT=3 instance is waiting
    base2 = resp_cnt[2];
    en = 1'b1; addr = 32'h1c00_0008; tick();
    check("wait_rdy0", 2, 64'(rdy[2]), 64'd0);
    addr = 32'h1c00_000c; tick();
    check("wait_rdy1", 2, 64'(rdy[2]), 64'd0);
    tick();
    check("wait_rdy2", 2, 64'(rdy[2]), 64'd0);
    en = 1'b0; tick();
    check("wait_resp", 2, 64'({rdy[2], rv[2], rd[2]}), 64'({1'b1, 1'b1, 32'hC0DE_0002}));
    repeat (6) tick();
    check("wait_count", 2, 64'(resp_cnt[2] - base2), 64'd1);

    // Reset two cycles after acceptance aborts the WAIT=3 request
    base2 = resp_cnt[2];
    en = 1'b1; addr = 32'h1c00_0010; tick();
    en = 1'b0; tick(); tick();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("abort_outs", 2, 64'({rdy[2], rv[2], er[2], rd[2]}), 64'd0);
    tick(); tick();
    rst = 1'b1;
    repeat (6) tick();
    check("abort_norsp", 2, 64'(resp_cnt[2] - base2), 64'd0);
    issue(32'h1c00_0014);
    for (int k = 0; k < NI; k++)
      check("post_reset", k, 64'({last_er[k], last_rd[k]}), 64'({1'b0, 32'hC0DE_0005}));
    tick();

    // Same-edge preload and read of word 5
    we = 1'b1; la = 4'd5; ld = 32'hAAAA_5555;
    en = 1'b1; addr = 32'h1c00_0014;
    tick();
    check("rbw_old", 0, 64'({rv[0], rd[0]}), 64'({1'b1, 32'hC0DE_0005}));
    we = 1'b0; en = 1'b0;
    repeat (6) tick();
    issue(32'h1c00_0014);
    for (int k = 0; k < NI; k++)
      check("rbw_new", k, 64'({last_er[k], last_rd[k]}), 64'({1'b0, 32'hAAAA_5555}));
    tick();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 5))
        0, 1, 2: addr = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
        3:       addr = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
        4:       addr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 3)) * 4 - 32'd8;
        default: addr = $urandom;
      endcase
      we = ($urandom_range(0, 3) == 0);
      la = 4'($urandom_range(0, DEPTH - 1));
      ld = $urandom;
      tick();
    end
    en = 1'b0; we = 1'b0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
